// File: rtl/mbist_pkg.sv
// Shared types and sizing for the MBIST repair-table loader and its lookup CAM.
package mbist_pkg;

  localparam int BIST_ADDR_WD   = 9;
  localparam int BIST_ERR_LIMIT = 4;
  localparam int FRAME_WD       = 16;
  localparam int FRAME_VLD_BIT  = 15;
  localparam int SLOT_IDX_WD    = (BIST_ERR_LIMIT > 1) ? $clog2(BIST_ERR_LIMIT) : 1;
  localparam int FRAME_CNT_WD   = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} repair_ld_st_t;

  typedef struct packed {
    logic                    vld;
    logic [BIST_ADDR_WD-1:0] addr;
  } repair_ent_t;

  function automatic logic [3:0] count_valid(input repair_ent_t [BIST_ERR_LIMIT-1:0] ents);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
      n = n + {3'b000, ents[i].vld};
    end
    return n;
  endfunction

endpackage

// File: rtl/mbist_repair_cam.sv
// Committed repair table with a zero-latency priority match that steers hits onto spare rows.
module mbist_repair_cam
  import mbist_pkg::*;
#(
  parameter logic [BIST_ADDR_WD-1:0] REPAIR_ADDR_START = 9'h1FC
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                commit,
  input  repair_ent_t [BIST_ERR_LIMIT-1:0]    stage,
  input  logic        [BIST_ADDR_WD-1:0]      addr_in,
  output logic        [BIST_ADDR_WD-1:0]      addr_out,
  output logic                                hit
);

  repair_ent_t [BIST_ERR_LIMIT-1:0] tbl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= '0;
    end else if (commit) begin
      tbl <= stage;
    end
  end

  // Scanning from the top slot down lets the lowest matching index overwrite the rest.
  always_comb begin
    addr_out = addr_in;
    hit      = 1'b0;
    for (int i = BIST_ERR_LIMIT - 1; i >= 0; i--) begin
      if (tbl[i].vld && (tbl[i].addr == addr_in)) begin
        hit      = 1'b1;
        addr_out = REPAIR_ADDR_START + BIST_ADDR_WD'(i);
      end
    end
  end

endmodule

// File: rtl/mbist_repair_load.sv
// Receive end of the repair-address scan chain: deserialises frames, stages them and
// commits the whole table atomically when the shift session ends.
module mbist_repair_load
  import mbist_pkg::*;
#(
  parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_shift,
  input  logic                    sdi,
  output logic                    sdo,
  input  logic [BIST_ADDR_WD-1:0] AddressIn,
  output logic [BIST_ADDR_WD-1:0] AddressOut,
  output logic                    repair_hit,
  output logic [3:0]              repair_cnt,
  output logic                    load_done,
  output logic                    load_err,
  output repair_ld_st_t           dbg_state
);

  // Session protocol: every clk with scan_shift=1 moves one sdi bit into the loader; the
  // first low cycle ends the session, and load_done pulses once with the new table already live.

  repair_ld_st_t                    state, state_nxt;
  logic [FRAME_WD-1:0]              sreg;
  logic [3:0]                       bit_cnt;
  logic [FRAME_CNT_WD-1:0]          frame_cnt;
  logic                             ovf;
  logic                             partial;
  repair_ent_t [BIST_ERR_LIMIT-1:0] stage;

  logic                             shift_en;
  logic                             frame_done;
  logic [FRAME_WD-1:0]              frame_word;
  logic                             slot_free;
  logic [SLOT_IDX_WD-1:0]           slot;
  logic                             unused_frame_bits;

  assign shift_en          = scan_shift && ((state == IDLE) || (state == SHIFT));
  assign frame_word        = {sdi, sreg[FRAME_WD-1:1]};
  assign frame_done        = (state == SHIFT) && scan_shift && (bit_cnt == 4'd15);
  assign slot_free         = frame_cnt < FRAME_CNT_WD'(BIST_ERR_LIMIT);
  assign slot              = frame_cnt[SLOT_IDX_WD-1:0];
  assign unused_frame_bits = ^frame_word[FRAME_VLD_BIT-1:BIST_ADDR_WD];
  assign sdo               = sreg[0];
  assign dbg_state         = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_shift) state_nxt = SHIFT;
      SHIFT:   if (!scan_shift) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE->SHIFT cycle already carries frame bit 0, so the bit counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      partial   <= 1'b0;
      stage     <= '0;
    end else begin
      if (shift_en) begin
        sreg <= frame_word;
      end
      if ((state == IDLE) && scan_shift) begin
        bit_cnt   <= 4'd1;
        frame_cnt <= '0;
        ovf       <= 1'b0;
        partial   <= 1'b0;
        for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
          stage[i].vld <= 1'b0;
        end
      end else if ((state == SHIFT) && scan_shift) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (frame_done) begin
          if (slot_free) begin
            stage[slot] <= repair_ent_t'({frame_word[FRAME_VLD_BIT], frame_word[BIST_ADDR_WD-1:0]});
            frame_cnt   <= frame_cnt + FRAME_CNT_WD'(1);
          end else begin
            ovf <= 1'b1;
          end
        end
      end else if (state == SHIFT) begin
        partial <= (bit_cnt != 4'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      repair_cnt <= '0;
    end else begin
      load_done <= (state == COMMIT);
      if (state == COMMIT) begin
        load_err   <= ovf | partial;
        repair_cnt <= count_valid(stage);
      end
    end
  end

  mbist_repair_cam #(
    .REPAIR_ADDR_START (BIST_REPAIR_ADDR_START)
  ) u_cam (
    .clk      (clk),
    .rst_n    (rst_n),
    .commit   (state == COMMIT),
    .stage    (stage),
    .addr_in  (AddressIn),
    .addr_out (AddressOut),
    .hit      (repair_hit)
  );

endmodule

// File: tb/tb_mbist_repair_load.sv
// Bench for mbist_repair_load: directed and random scan sessions against a frame-list model.
module tb_mbist_repair_load;
  import mbist_pkg::*;

  localparam logic [8:0] START = 9'h1FC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan_shift;
  logic          sdi;
  logic          sdo;
  logic [8:0]    AddressIn;
  logic [8:0]    AddressOut;
  logic          repair_hit;
  logic [3:0]    repair_cnt;
  logic          load_done;
  logic          load_err;
  repair_ld_st_t dbg_state;

  mbist_repair_load #(.BIST_REPAIR_ADDR_START(START)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_shift (scan_shift),
    .sdi        (sdi),
    .sdo        (sdo),
    .AddressIn  (AddressIn),
    .AddressOut (AddressOut),
    .repair_hit (repair_hit),
    .repair_cnt (repair_cnt),
    .load_done  (load_done),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // expected commit record: [44:41] count, [40] error, slot i at [i*10 +: 10] = {vld, addr}
  int          tests = 0;
  int          fails = 0;
  logic [44:0] exp_q[$];
  logic [44:0] mon_e;
  logic        m_vld[4];
  logic [8:0]  m_addr[4];
  logic [15:0] sess_frames[$];
  logic        hist[$];

  // scoreboard monitor: every load_done pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (rst_n && load_done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL load_done_unexpected: pulse seen, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        if (repair_cnt !== mon_e[44:41] || load_err !== mon_e[40]) begin
          fails++;
          $display("FAIL commit_status: cnt=%0d err=%0b expected cnt=%0d err=%0b",
                   repair_cnt, load_err, mon_e[44:41], mon_e[40]);
        end
        for (int i = 0; i < 4; i++) begin
          m_vld[i]  = mon_e[i*10+9];
          m_addr[i] = mon_e[i*10 +: 9];
        end
      end
    end
  end

  // driver and check tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      m_vld[i]  = 1'b0;
      m_addr[i] = '0;
    end
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
  endtask

  task automatic shift_word(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      check("sdo_echo", {31'b0, sdo}, {31'b0, hist[hist.size()-16]});
      scan_shift = 1'b1;
      sdi        = w[i];
      hist.push_back(w[i]);
    end
  endtask

  task automatic expect_session(input int extra_bits);
    logic [44:0] e;
    logic [3:0]  cnt;
    int          n;
    e   = '0;
    cnt = '0;
    n   = sess_frames.size();
    for (int i = 0; i < 4 && i < n; i++) begin
      e[i*10+9]   = sess_frames[i][15];
      e[i*10 +: 9] = sess_frames[i][8:0];
      cnt         = cnt + {3'b000, sess_frames[i][15]};
    end
    e[44:41] = cnt;
    e[40]    = (n > 4) || (extra_bits != 0);
    exp_q.push_back(e);
  endtask

  task automatic end_session();
    @(negedge clk);
    scan_shift = 1'b0;
    sdi        = 1'b0;
    repeat (3) @(negedge clk);
    check("commit_drain", exp_q.size(), 0);
  endtask

  task automatic run_session(input int extra_bits, input logic [15:0] extra);
    foreach (sess_frames[k]) shift_word(sess_frames[k], 16);
    if (extra_bits > 0) shift_word(extra, extra_bits);
    expect_session(extra_bits);
    end_session();
  endtask

  task automatic check_remap(input logic [8:0] addr);
    logic [8:0] exp_a;
    logic       exp_h;
    AddressIn = addr;
    #1;
    exp_a = addr;
    exp_h = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (m_vld[i] && m_addr[i] == addr) begin
        exp_a = START + 9'(i);
        exp_h = 1'b1;
      end
    end
    check("remap_addr", {23'b0, AddressOut}, {23'b0, exp_a});
    check("remap_hit", {31'b0, repair_hit}, {31'b0, exp_h});
  endtask

  // stimulus
  initial begin
    logic [8:0] a;
    int         n;
    int         xb;
    rst_n      = 1'b0;
    scan_shift = 1'b0;
    sdi        = 1'b0;
    AddressIn  = '0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr_out", {23'b0, AddressOut}, 0);
    check("rst_hit", {31'b0, repair_hit}, 0);
    check("rst_cnt", {28'b0, repair_cnt}, 0);
    check("rst_done", {31'b0, load_done}, 0);
    check("rst_err", {31'b0, load_err}, 0);
    check("rst_sdo", {31'b0, sdo}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic four-frame table with one padding slot
    sess_frames = '{16'h8005, 16'h8010, 16'h0000, 16'h81F0};
    run_session(0, 16'h0);
    check_remap(9'h005);
    check_remap(9'h010);
    check_remap(9'h1F0);
    check_remap(9'h011);
    check_remap(9'h000);

    // overflow: fifth frame dropped
    sess_frames = '{16'h8101, 16'h8102, 16'h8103, 16'h8104, 16'h8105};
    run_session(0, 16'h0);
    check_remap(9'h104);
    check_remap(9'h105);

    // partial trailing frame discarded
    sess_frames = '{16'h8077};
    run_session(7, 16'h80FF);
    check_remap(9'h077);
    check_remap(9'h101);
    check_remap(9'h0FF);

    // double buffering: table A stays live until the commit of table B
    sess_frames = '{16'h8030, 16'h8031};
    run_session(0, 16'h0);
    sess_frames = '{16'h8040, 16'h8030};
    shift_word(16'h8040, 16);
    check_remap(9'h030);
    check_remap(9'h040);
    shift_word(16'h8030, 16);
    expect_session(0);
    @(negedge clk);
    scan_shift = 1'b0;
    @(negedge clk);
    check_remap(9'h031);
    check_remap(9'h030);
    @(negedge clk);
    check_remap(9'h031);
    check_remap(9'h040);
    check_remap(9'h030);
    @(negedge clk);
    check("commit_drain", exp_q.size(), 0);

    // duplicate entries: lowest slot wins
    sess_frames = '{16'h8020, 16'h8020};
    run_session(0, 16'h0);
    check_remap(9'h020);

    // reset in the middle of frame 2
    sess_frames = '{16'h8055, 16'h8066};
    shift_word(16'h8055, 16);
    shift_word(16'h8066, 7);
    @(negedge clk);
    rst_n      = 1'b0;
    scan_shift = 1'b0;
    AddressIn  = '0;
    #1;
    check("mid_rst_addr_out", {23'b0, AddressOut}, 0);
    check("mid_rst_hit", {31'b0, repair_hit}, 0);
    check("mid_rst_cnt", {28'b0, repair_cnt}, 0);
    check("mid_rst_done", {31'b0, load_done}, 0);
    check("mid_rst_err", {31'b0, load_err}, 0);
    check("mid_rst_sdo", {31'b0, sdo}, 0);
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_remap(9'h020);
    check_remap(9'h055);
    check("mid_rst_no_commit", exp_q.size(), 0);
    sess_frames.delete();
    for (int i = 0; i < 3; i++) sess_frames.push_back(16'($urandom));
    run_session(0, 16'h0);

    // random sessions over a small address pool to provoke duplicates
    for (int s = 0; s < 10; s++) begin
      sess_frames.delete();
      n = $urandom_range(0, 6);
      for (int f = 0; f < n; f++) begin
        a = 9'h0A0 + 9'($urandom_range(0, 7));
        sess_frames.push_back({($urandom_range(0, 3) != 0), 6'($urandom), a});
      end
      xb = (n == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
      run_session(xb, 16'($urandom));
      for (int k = 0; k < 6; k++) check_remap(9'h0A0 + 9'($urandom_range(0, 7)));
      check_remap(9'($urandom));
    end

    repeat (4) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
